// File: rtl/atomic_counters_pkg.sv
// Shared widths and types for the atomic event counter block.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package atomic_counters_pkg;

  localparam int DEF_DATABUS  = 32;
  localparam int DEF_COUNTLEN = 2 * DEF_DATABUS;

  typedef logic [DEF_COUNTLEN-1:0] count_t;
  typedef logic [DEF_DATABUS-1:0]  bus_t;

endpackage

// File: rtl/atomic_counters_core.sv
// Free-running enable counter, wraps silently from all-ones to zero.
// Latency: count visible one cycle after the enabling edge.
// Backpressure: none; every enabled cycle is counted.
module atomic_counters_core
  import atomic_counters_pkg::*;
#(
  parameter int WIDTH = DEF_COUNTLEN
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] cnt_q;

  // Count one per enabled cycle; async clear on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/atomic_counters.sv
// Wide event counter read as two coherent bus-width halves over req/ack.
// Latency: ack_o and count_o one cycle after the request edge.
// Backpressure: none; back-to-back requests are acked back-to-back.
module atomic_counters
  import atomic_counters_pkg::*;
#(
  parameter int DATABUS  = DEF_DATABUS,
  parameter int COUNTLEN = DEF_COUNTLEN
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               trig_i,
  input  logic               req_i,
  input  logic               atomic_i,
  output logic               ack_o,
  output logic [DATABUS-1:0] count_o
);

  // The snapshot scheme splits the counter into exactly two bus words.
  if (COUNTLEN != 2 * DATABUS) begin : g_bad_width
    $error("atomic_counters: COUNTLEN must equal 2*DATABUS");
  end

  logic [COUNTLEN-1:0] cnt;
  logic [DATABUS-1:0]  hi_snap;
  logic                pending;

  atomic_counters_core #(
    .WIDTH (COUNTLEN)
  ) u_core (
    .clk   (clk),
    .reset (reset),
    .en    (trig_i),
    .cnt   (cnt)
  );

  // Ack is the request delayed by one cycle; no stall path exists.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ack_o <= 1'b0;
    end else begin
      ack_o <= req_i;
    end
  end

  // Read path: the low read captures the high half so the pair stays coherent
  // even if the counter carries between the two accesses. cnt here is the
  // pre-increment value, so a same-edge trigger is counted but not returned.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_o <= '0;
      hi_snap <= '0;
      pending <= 1'b0;
    end else if (req_i) begin
      if (atomic_i) begin
        count_o <= cnt[DATABUS-1:0];
        hi_snap <= cnt[COUNTLEN-1:DATABUS];
        pending <= 1'b1;
      end else if (pending) begin
        count_o <= hi_snap;
        pending <= 1'b0;
      end else begin
        count_o <= cnt[DATABUS-1:0];
      end
    end
  end

endmodule

// File: tb/tb_atomic_counters.sv
// Directed bench for atomic_counters with a scoreboard of expected read data.
// Latency: checks ack one cycle after each request edge.
// Backpressure: n/a.
module tb_atomic_counters;
  import atomic_counters_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic trig_i = 1'b0;
  logic req_i = 1'b0;
  logic atomic_i = 1'b0;
  logic ack_o;
  bus_t count_o;

  int checks = 0;
  int errors = 0;

  bus_t exp_q[$];
  bus_t last_data;
  bus_t exp_d;
  logic prev_req;

  always #5 clk = ~clk;

  atomic_counters #(
    .DATABUS  (DEF_DATABUS),
    .COUNTLEN (DEF_COUNTLEN)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .trig_i   (trig_i),
    .req_i    (req_i),
    .atomic_i (atomic_i),
    .ack_o    (ack_o),
    .count_o  (count_o)
  );

  // Expected ack is simply the request seen at the previous rising edge.
  always @(posedge clk or negedge reset) begin
    if (!reset) prev_req <= 1'b0;
    else        prev_req <= req_i;
  end

  // Monitor on the falling edge: ack timing, scoreboard data, hold behaviour.
  always @(negedge clk) begin
    if (!reset) begin
      last_data = '0;
    end else begin
      checks++;
      assert (ack_o === prev_req) else begin
        errors++;
        $error("FAIL ack_timing: observed %b expected %b", ack_o, prev_req);
      end
      if (ack_o === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $error("FAIL unexpected_ack: observed data %h expected no ack", count_o);
        end else begin
          exp_d = exp_q.pop_front();
          assert (count_o === exp_d) else begin
            errors++;
            $error("FAIL read_data: observed %h expected %h", count_o, exp_d);
          end
        end
        last_data = count_o;
      end else begin
        checks++;
        assert (count_o === last_data) else begin
          errors++;
          $error("FAIL data_hold: observed %h expected %h", count_o, last_data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic trig(input int n);
    trig_i = 1'b1;
    repeat (n) tick();
    trig_i = 1'b0;
  endtask

  task automatic rd(input logic atomic, input bus_t exp, input logic with_trig);
    req_i    = 1'b1;
    atomic_i = atomic;
    trig_i   = with_trig;
    exp_q.push_back(exp);
    tick();
    req_i    = 1'b0;
    atomic_i = 1'b0;
    trig_i   = 1'b0;
  endtask

  task automatic reset_pulse();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic preload(input count_t val);
    force dut.u_core.cnt_q = val;
    @(negedge clk);
    release dut.u_core.cnt_q;
    tick();
  endtask

  initial begin
    // Reset held for two cycles, then released.
    repeat (2) tick();
    reset = 1'b1;
    checks++;
    assert (ack_o === 1'b0) else begin
      errors++;
      $error("FAIL reset_ack: observed %b expected 0", ack_o);
    end
    checks++;
    assert (count_o === '0) else begin
      errors++;
      $error("FAIL reset_count: observed %h expected 0", count_o);
    end
    rd(1'b0, 32'h0000_0000, 1'b0);
    tick();

    // Ten events then a plain read.
    trig(10);
    rd(1'b0, 32'd10, 1'b0);
    tick();

    // Carry coherency across the two halves.
    preload(64'h0000_0000_FFFF_FFFE);
    rd(1'b1, 32'hFFFF_FFFE, 1'b0);
    trig(5);
    rd(1'b0, 32'h0000_0000, 1'b0);
    rd(1'b0, 32'h0000_0003, 1'b0);
    rd(1'b1, 32'h0000_0003, 1'b0);
    rd(1'b0, 32'h0000_0001, 1'b0);
    tick();

    // Trigger and request on the same edge at count 7.
    reset_pulse();
    trig(7);
    rd(1'b0, 32'd7, 1'b1);
    rd(1'b0, 32'd8, 1'b0);
    tick();

    // Back-to-back atomic pair.
    rd(1'b1, 32'd8, 1'b0);
    rd(1'b0, 32'd0, 1'b0);
    tick();

    // A second low read while pending replaces the snapshot.
    preload(64'h0000_0000_FFFF_FFFF);
    rd(1'b1, 32'hFFFF_FFFF, 1'b0);
    trig(1);
    rd(1'b1, 32'h0000_0000, 1'b0);
    rd(1'b0, 32'h0000_0001, 1'b0);
    tick();

    // Reset in the middle of an atomic pair drops the pending high read.
    rd(1'b1, 32'h0000_0000, 1'b0);
    tick();
    reset_pulse();
    trig(3);
    rd(1'b0, 32'd3, 1'b0);

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL drain: observed %0d outstanding reads expected 0", exp_q.size());
    end
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
